keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  Scans a 4x4 matrix keypad for the password lock, paced by the clock divider's output (nominal 1 kHz).
//  Drives the columns, synchronises and debounces the rows, and sends one clean key event per press
//  to the password FSM downstream.
//  Runs entirely in the system clk domain; the divided clock is used only as a strobe source, never as a clock.
// PARAMETERS
//  DEBOUNCE_TICKS  20  consecutive stable tick samples required to accept a press or a release (20 ms at 1 kHz); legal range >= 2
// PORTS
//  clk        in   1  system clock (50 MHz)
//  rst        in   1  asynchronous, active-low reset
//  tick_clk   in   1  divided clock from clock divider; generated by a flop in the clk domain
//  rows       in   4  keypad rows, active-low (external pull-ups), asynchronous
//  cols       out  4  keypad column drive, one-hot active-low
//  key_code   out  4  code of the last accepted key; held until the next accepted key
//  key_valid  out  1  one-clk pulse when key_code is updated
//  key_held   out  1  high from acceptance until the release is debounced
// BEHAVIOUR
//  - Reset (async, rst=0): state=SCAN, col_idx=0, cols=4'b1110, key_code=0, key_valid=0, key_held=0, cnt=0; sync flops cleared.
//  - tick: registered rising-edge detect of tick_clk (tick = tick_clk & ~tick_clk_q); 1 clk wide. All FSM moves occur only on tick cycles.
//  - rows pass through a 2-FF synchroniser (reset to 4'hF) -> rows_s. "pressed(r)" means rows_s[r]==0.
//  - Row priority: if several rows are low, the lowest row index wins.
//  - cols = ~(4'b0001 << col_idx) at all times.
//  - SCAN: on tick, if any row is pressed: latch row_idx, cnt=0, go to DEBOUNCE (col_idx frozen).
//    Otherwise col_idx = col_idx+1 (3 wraps to 0).
//  - DEBOUNCE: on tick, if pressed(row_idx): if cnt==DEBOUNCE_TICKS-1, then key_code=KEY_LUT[row_idx][col_idx],
//    key_valid=1 on the next clk, key_held=1, go to HOLD. Otherwise cnt++.
//    If row_idx is not pressed: go to SCAN, col_idx unchanged, and no event is sent.
//  - HOLD: no column advance. On tick, if !pressed(row_idx): cnt=0, go to RELEASE.
//    Pressing other keys in this state is ignored.
//  - RELEASE: on tick, if !pressed(row_idx): if cnt==DEBOUNCE_TICKS-1, then key_held=0, go to SCAN. Otherwise cnt++.
//    If pressed(row_idx) again: go to HOLD (bounce). No second key_valid is sent.
//  - Latency: key_valid asserts exactly 1 clk after the DEBOUNCE_TICKS-th consecutive pressed tick following the detection tick.
//    The synchroniser adds 2 clk to row sampling.
//  - Exactly one key_valid per physical press, however long the key is held (no auto-repeat).
//  - cnt width: $clog2(DEBOUNCE_TICKS); it never exceeds DEBOUNCE_TICKS-1.
//  - Reset mid-operation: the FSM is abandoned at once and no pending event is sent. After reset, a key still held
//    is detected again as a new press.
//  - tick stuck (divider held in reset): the FSM stays frozen and outputs hold their values.
//  - KEY_LUT (row-major):
//      row0 = 1 2 3 A
//      row1 = 4 5 6 B
//      row2 = 7 8 9 C
//      row3 = E(*) 0 F(#) D
// STRUCTURE
//  - keypad_pkg: state encoding (SCAN, DEBOUNCE, HOLD, RELEASE), N_ROWS/N_COLS=4, and the KEY_LUT function (row, col) -> 4-bit code.
//  - Sub-module sync_2ff (parameterised width, async active-low reset, reset value parameter) for rows.
//  - Tick edge detect, FSM, cnt, and output registers are inline.
// TESTING (bench: DEBOUNCE_TICKS=4; tick_clk driven from a clock divider with a small count so that a tick occurs every 10 clk)
//  1. Assert and release rst with rows=4'hF.
//     -> cols=1110, key_code=0, key_valid=0, key_held=0; cols then rotate 1101, 1011, 0111, 1110 on successive ticks.
//  2. Model key '5' (row1 low only while cols[1]=0) for 20 ticks, then release.
//     -> exactly one key_valid pulse, key_code=4'h5, key_held=1 until 4 clean ticks after release.
//  3. Key '#' (row3, col2) bounces: low for 2 ticks, high for 1, low for 2, then high.
//     -> no key_valid; FSM returns to SCAN; key_code remains at its previous value.
//  4. Hold '7' for 100 ticks with release bounce (high 1, low 1, high 6).
//     -> single key_valid with code 4'h7; key_held stays 1 through the bounce and drops after 4 clean ticks.
//  5. Press row0 and row2 simultaneously in col3.
//     -> key_code=4'hA (lowest row wins); pressing '1' during HOLD of 'A' gives no event.
//  6. Pull rst low during DEBOUNCE (cnt=2) for 3 clk while key '0' is held.
//     -> outputs go to reset values; after release of rst, '0' is detected afresh; key_valid code 4'h0 after 1+4 ticks.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM states, matrix size and key map.
package keypad_pkg;

    localparam int N_ROWS = 4;
    localparam int N_COLS = 4;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    // Row-major key map; '*' reads as E and '#' reads as F.
    function automatic logic [3:0] key_lut(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hE;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hF;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs, with a configurable reset value.
module sync_2ff #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two-stage capture; the first stage may go metastable, the second is safe to use.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: walks the columns on each divider tick, debounces the
// detected row, and emits one key event per press (no auto-repeat).
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_clk,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_TICKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             tick_clk_q;
    logic             tick;
    logic [3:0]       rows_s;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       col_q, col_d;
    logic [1:0]       row_q, row_d;

    logic             any_pressed;
    logic [1:0]       first_row;
    logic             row_pressed;
    logic             accept;
    logic             release_done;

    // Remember the previous divider level so only its rising edge produces a strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tick_clk_q <= 1'b0;
        else      tick_clk_q <= tick_clk;
    end

    assign tick = tick_clk & ~tick_clk_q;

    sync_2ff #(
        .WIDTH   (N_ROWS),
        .RST_VAL (4'hF)
    ) u_rows_sync (
        .clk (clk),
        .rst (rst),
        .d   (rows),
        .q   (rows_s)
    );

    // Lowest-numbered low row wins when several rows are pulled down together.
    always_comb begin
        first_row = 2'd0;
        for (int r = N_ROWS - 1; r >= 0; r--) begin
            if (!rows_s[r]) first_row = 2'(r);
        end
    end

    assign any_pressed = ~&rows_s;
    assign row_pressed = ~rows_s[row_q];

    // FSM state, debounce counter, and the latched column/row of the key being tracked.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SCAN;
            cnt_q   <= '0;
            col_q   <= 2'd0;
            row_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    // Next-state logic; nothing moves except on a tick, so a stuck divider freezes the scanner.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        row_d   = row_q;
        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (any_pressed) begin
                        row_d   = first_row;
                        cnt_d   = '0;
                        state_d = DEBOUNCE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (row_pressed) begin
                        if (cnt_q == CNT_LAST) state_d = HOLD;
                        else                   cnt_d   = cnt_q + CNT_ONE;
                    end else begin
                        state_d = SCAN;
                    end
                end
                HOLD: begin
                    if (!row_pressed) begin
                        cnt_d   = '0;
                        state_d = RELEASE;
                    end
                end
                RELEASE: begin
                    if (!row_pressed) begin
                        if (cnt_q == CNT_LAST) state_d = SCAN;
                        else                   cnt_d   = cnt_q + CNT_ONE;
                    end else begin
                        state_d = HOLD;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    // Output decisions: a press is accepted or a release completes on the final debounce tick.
    always_comb begin
        accept       = 1'b0;
        release_done = 1'b0;
        if (tick && (cnt_q == CNT_LAST)) begin
            accept       = (state_q == DEBOUNCE) &&  row_pressed;
            release_done = (state_q == RELEASE)  && !row_pressed;
        end
    end

    // Registered key outputs; key_valid is a single-cycle pulse aligned with the new key_code.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= accept;
            if (accept) begin
                key_code <= key_lut(row_q, col_q);
                key_held <= 1'b1;
            end else if (release_done) begin
                key_held <= 1'b0;
            end
        end
    end

    assign cols = ~(4'b0001 << col_q);

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical keypad model drives rows from cols, and a
// run-length reference model predicts columns, key codes, event pulses and key_held.
module tb_keypad_scanner;

    localparam int DT = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_clk;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    int vectors     = 0;
    int miscompares = 0;
    int valid_pulses = 0;

    // Physical key switches: key_down[row][col]
    bit key_down [4][4];

    // Reference model state
    int         m_col;
    int         m_row;
    int         run;
    int         rel_run;
    bit         engaged;
    bit         held;
    logic [3:0] m_code;
    int         accepts;

    logic [3:0] lut [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                             4'h4, 4'h5, 4'h6, 4'hB,
                             4'h7, 4'h8, 4'h9, 4'hC,
                             4'hE, 4'h0, 4'hF, 4'hD};

    keypad_scanner #(.DEBOUNCE_TICKS(DT)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick_clk  (tick_clk),
        .rows      (rows),
        .cols      (cols),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // A closed switch pulls its row low while its column is driven low.
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (key_down[r][c] && !cols[c]) rows[r] = 1'b0;
    end

    always @(posedge clk) begin
        if (key_valid === 1'b1) valid_pulses <= valid_pulses + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_keys();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                key_down[r][c] = 1'b0;
    endtask

    task automatic model_reset();
        m_col = 0; m_row = 0; run = 0; rel_run = 0;
        engaged = 1'b0; held = 1'b0; m_code = 4'h0;
    endtask

    function automatic logic [3:0] exp_cols();
        logic [3:0] one;
        one = 4'b0001 << m_col;
        return ~one;
    endfunction

    // One scan step in terms of run lengths: a press needs DT further pressed
    // ticks after detection; a release needs DT+1 consecutive unpressed ticks.
    task automatic model_tick(output bit acc);
        int found;
        acc = 1'b0;
        if (!engaged) begin
            found = -1;
            for (int r = 0; r < 4; r++)
                if (found < 0 && key_down[r][m_col]) found = r;
            if (found >= 0) begin
                engaged = 1'b1; m_row = found; run = 0;
            end else begin
                m_col = (m_col + 1) % 4;
            end
        end else if (!held) begin
            if (key_down[m_row][m_col]) begin
                run++;
                if (run == DT) begin
                    held = 1'b1; rel_run = 0; acc = 1'b1; accepts++;
                    m_code = lut[m_row*4 + m_col];
                end
            end else begin
                engaged = 1'b0;
            end
        end else begin
            if (!key_down[m_row][m_col]) begin
                rel_run++;
                if (rel_run == DT + 1) begin
                    held = 1'b0; engaged = 1'b0;
                end
            end else begin
                rel_run = 0;
            end
        end
    endtask

    // One divider period: 5 clk low, rising edge, 5 clk high.
    task automatic one_tick();
        bit acc;
        repeat (5) @(negedge clk);
        tick_clk = 1'b1;
        model_tick(acc);
        @(negedge clk);
        chk("cols", cols, exp_cols());
        chk("key_code", key_code, m_code);
        chk("key_valid", key_valid, acc);
        chk("key_held", key_held, held);
        @(negedge clk);
        chk("key_valid_1clk", key_valid, 1'b0);
        repeat (3) @(negedge clk);
        tick_clk = 1'b0;
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) one_tick();
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_cols", cols, 4'b1110);
        chk("rst_code", key_code, 4'h0);
        chk("rst_valid", key_valid, 1'b0);
        chk("rst_held", key_held, 1'b0);
        repeat (n) @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        int base;
        int r, c, len, gap;
        rst = 1'b0;
        tick_clk = 1'b0;
        clear_keys();
        model_reset();
        accepts = 0;

        // 1: reset state and idle column rotation
        #2;
        chk("init_cols", cols, 4'b1110);
        chk("init_code", key_code, 4'h0);
        chk("init_valid", key_valid, 1'b0);
        chk("init_held", key_held, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        run_ticks(8);

        // 2: key '5' held 20 ticks, then released
        base = valid_pulses;
        key_down[1][1] = 1'b1;
        run_ticks(20);
        chk("s2_held", key_held, 1'b1);
        key_down[1][1] = 1'b0;
        run_ticks(8);
        chk("s2_pulses", valid_pulses - base, 1);
        chk("s2_code", key_code, 4'h5);
        chk("s2_released", key_held, 1'b0);

        // 3: '#' bounces, never stable long enough
        base = valid_pulses;
        key_down[3][2] = 1'b1; run_ticks(2);
        key_down[3][2] = 1'b0; run_ticks(1);
        key_down[3][2] = 1'b1; run_ticks(2);
        key_down[3][2] = 1'b0; run_ticks(6);
        chk("s3_pulses", valid_pulses - base, 0);
        chk("s3_code", key_code, 4'h5);

        // 4: '7' held 100 ticks with a bouncy release
        base = valid_pulses;
        key_down[2][0] = 1'b1; run_ticks(100);
        key_down[2][0] = 1'b0; run_ticks(1);
        key_down[2][0] = 1'b1; run_ticks(1);
        chk("s4_held_bounce", key_held, 1'b1);
        key_down[2][0] = 1'b0; run_ticks(6);
        chk("s4_pulses", valid_pulses - base, 1);
        chk("s4_code", key_code, 4'h7);
        chk("s4_released", key_held, 1'b0);

        // 5: rows 0 and 2 together in column 3, then '1' pressed during the hold
        base = valid_pulses;
        key_down[0][3] = 1'b1; key_down[2][3] = 1'b1;
        run_ticks(12);
        chk("s5_code", key_code, 4'hA);
        key_down[0][0] = 1'b1;
        run_ticks(5);
        clear_keys();
        run_ticks(8);
        chk("s5_pulses", valid_pulses - base, 1);
        chk("s5_code_after", key_code, 4'hA);

        // Stuck divider: nothing moves while tick_clk stays low
        run_ticks(2);
        repeat (40) @(negedge clk);
        chk("stuck_cols", cols, exp_cols());
        chk("stuck_valid", key_valid, 1'b0);

        // 6: reset during debounce of '0', then the held key is seen afresh
        key_down[3][1] = 1'b1;
        for (int i = 0; i < 20 && !(engaged && !held && run == 2); i++) one_tick();
        chk("s6_reach_cnt2", (engaged && !held && run == 2), 1'b1);
        base = valid_pulses;
        do_reset(3);
        run_ticks(10);
        chk("s6_pulses", valid_pulses - base, 1);
        chk("s6_code", key_code, 4'h0);
        chk("s6_held", key_held, 1'b1);
        clear_keys();
        run_ticks(8);

        // Random presses of random length, sometimes with a second key overlapping
        for (int k = 0; k < 50; k++) begin
            r = int'($urandom_range(0, 3));
            c = int'($urandom_range(0, 3));
            len = int'($urandom_range(1, 10));
            gap = int'($urandom_range(1, 7));
            key_down[r][c] = 1'b1;
            if ($urandom_range(0, 3) == 0)
                key_down[$urandom_range(0, 3)][$urandom_range(0, 3)] = 1'b1;
            run_ticks(len);
            clear_keys();
            run_ticks(gap);
        end
        run_ticks(8);
        @(negedge clk);
        chk("total_pulses", valid_pulses, accepts);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
